mem_arbiter: RTL and testbench

- Shares the single-port synchronous RAM (24-bit address, 8-bit data, registered read, `WE`/`RDY` qualified) between the 65C24T8 CPU and one DMA requester.
- Sits between the CPU core, the DMA engine and the `ram` instance, and drives the RAM port signals `AB`/`DO`/`WE`/`RDY`.
- Stalls the CPU through its `RDY` input while DMA owns the port.
- Preserves the CPU's pending read data across DMA cycles and bounds DMA bursts for CPU fairness.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares the single-port RAM between the CPU and one DMA requester, stalling the CPU
// through cpu_RDY while DMA owns the port and capping DMA bursts at MAX_BURST grants.
module mem_arbiter #(
    parameter int              AW        = 24,
    parameter int              DW        = 8,
    parameter int              MAX_BURST = 16,
    parameter logic [AW-1:0]   VEC_BASE  = 24'hFFFFF0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ext_rdy,
    input  logic [AW-1:0] cpu_AB,
    input  logic [DW-1:0] cpu_DO,
    input  logic          cpu_WE,
    output logic [DW-1:0] cpu_DI,
    output logic          cpu_RDY,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_we,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_err,
    output logic [AW-1:0] mem_AB,
    output logic [DW-1:0] mem_DO,
    output logic          mem_WE,
    output logic          mem_RDY,
    input  logic [DW-1:0] mem_DI,
    output logic          dbg_state_o,
    output logic [7:0]    dbg_burst_cnt_o
);

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t        state_q;
    logic [7:0]    burst_cnt_q;
    owner_t        owner_q;
    owner_t        owner_d;
    logic [DW-1:0] cpu_di_hold_q;
    logic          dma_rvalid_q;
    logic          dma_err_q;
    logic          in_dma;
    logic          vec_hit;

    assign in_dma  = (state_q == S_DMA);
    assign vec_hit = (dma_addr >= VEC_BASE);

    // Handshake: a DMA access is accepted in every cycle where dma_req and dma_gnt are
    // both high; an accepted read returns dma_rdata with dma_rvalid exactly one cycle later.
    assign mem_AB  = in_dma ? dma_addr  : cpu_AB;
    assign mem_DO  = in_dma ? dma_wdata : cpu_DO;
    assign mem_WE  = in_dma ? (dma_we & dma_req & ~vec_hit) : cpu_WE;
    assign mem_RDY = in_dma ? (ext_rdy & dma_req) : ext_rdy;
    assign cpu_RDY = ~in_dma & ext_rdy;
    assign dma_gnt = in_dma & ext_rdy & dma_req;

    // The CPU sees live RAM data only right after its own access; otherwise the held copy.
    assign cpu_DI     = (owner_q == OWN_CPU) ? mem_DI : cpu_di_hold_q;
    assign dma_rdata  = mem_DI;
    assign dma_rvalid = dma_rvalid_q;
    assign dma_err    = dma_err_q;

    assign dbg_state_o     = state_q;
    assign dbg_burst_cnt_o = burst_cnt_q;

    always_comb begin
        owner_d = OWN_NONE;
        if (mem_RDY) begin
            owner_d = in_dma ? OWN_DMA : OWN_CPU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CPU;
            burst_cnt_q <= '0;
        end else if (ext_rdy) begin
            case (state_q)
                S_CPU: begin
                    if (dma_req) begin
                        state_q     <= S_DMA;
                        burst_cnt_q <= '0;
                    end
                end
                S_DMA: begin
                    if (!dma_req || burst_cnt_q == BURST_LAST) begin
                        state_q <= S_CPU;
                    end else begin
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_CPU;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q       <= OWN_CPU;
            cpu_di_hold_q <= '0;
            dma_rvalid_q  <= 1'b0;
            dma_err_q     <= 1'b0;
        end else begin
            dma_rvalid_q <= dma_gnt & ~dma_we;
            dma_err_q    <= dma_gnt & dma_we & vec_hit;
            if (ext_rdy) begin
                owner_q <= owner_d;
                if (owner_q == OWN_CPU) begin
                    cpu_di_hold_q <= mem_DI;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: sparse RAM model, a cycle-level reference of the sharing rules,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

    localparam int          AW        = 24;
    localparam int          DW        = 8;
    localparam int          MAX_BURST = 16;
    localparam logic [23:0] VEC_BASE  = 24'hFFFFF0;

    logic          clk = 1'b0;
    logic          reset;
    logic          ext_rdy;
    logic [23:0]   cpu_AB;
    logic [7:0]    cpu_DO;
    logic          cpu_WE;
    logic [7:0]    cpu_DI;
    logic          cpu_RDY;
    logic          dma_req;
    logic [23:0]   dma_addr;
    logic [7:0]    dma_wdata;
    logic          dma_we;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [7:0]    dma_rdata;
    logic          dma_err;
    logic [23:0]   mem_AB;
    logic [7:0]    mem_DO;
    logic          mem_WE;
    logic          mem_RDY;
    logic [7:0]    mem_DI = 8'h00;
    logic          dbg_state_o;
    logic [7:0]    dbg_burst_cnt_o;

    int n_checks = 0;
    int n_err    = 0;

    mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .VEC_BASE(VEC_BASE)
    ) dut (
        .clk(clk), .reset(reset), .ext_rdy(ext_rdy),
        .cpu_AB(cpu_AB), .cpu_DO(cpu_DO), .cpu_WE(cpu_WE),
        .cpu_DI(cpu_DI), .cpu_RDY(cpu_RDY),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_AB(mem_AB), .mem_DO(mem_DO), .mem_WE(mem_WE), .mem_RDY(mem_RDY),
        .mem_DI(mem_DI),
        .dbg_state_o(dbg_state_o), .dbg_burst_cnt_o(dbg_burst_cnt_o)
    );

    always #5 clk = ~clk;

    // ---------------- RAM contents ----------------
    logic [7:0] ram_mem [logic [23:0]];
    logic [7:0] ref_mem [logic [23:0]];

    function automatic logic [7:0] preload(input logic [23:0] a);
        case (a)
            24'h000010: return 8'h5A;
            24'h000200: return 8'h77;
            24'h001000: return 8'h11;
            24'h001001: return 8'h22;
            24'h001002: return 8'h33;
            24'h001003: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hC3;
        endcase
    endfunction

    function automatic logic [7:0] ram_rd(input logic [23:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : preload(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : preload(a);
    endfunction

    // Registered-read RAM; the vector region is read-only.
    always @(posedge clk) begin
        if (mem_RDY) begin
            mem_DI <= ram_rd(mem_AB);
            if (mem_WE && mem_AB < VEC_BASE) ram_mem[mem_AB] = mem_DO;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + compare ----------------
    logic       m_turn = 1'b0;
    int         m_used = 0;
    logic       m_cpu_valid = 1'b0;
    logic [7:0] m_cpu_di = 8'h00;
    logic       m_err = 1'b0;
    logic [7:0] exp_q [$];
    logic       a_cpu;
    logic       a_dma;
    logic [7:0] e_rd;

    always @(negedge clk) begin
        if (reset) begin
            m_turn      = 1'b0;
            m_used      = 0;
            m_cpu_valid = 1'b0;
            m_err       = 1'b0;
            exp_q.delete();
        end
        check("dma_rvalid", 32'(dma_rvalid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e_rd = exp_q.pop_front();
            if (dma_rvalid) check("dma_rdata", 32'(dma_rdata), 32'(e_rd));
        end
        check("dma_err", 32'(dma_err), 32'(m_err));
        if (m_cpu_valid) check("cpu_DI", 32'(cpu_DI), 32'(m_cpu_di));

        a_cpu = ext_rdy && !m_turn;
        a_dma = ext_rdy && m_turn && dma_req;
        check("cpu_RDY", 32'(cpu_RDY), 32'(a_cpu));
        check("dma_gnt", 32'(dma_gnt), 32'(a_dma));
        check("mem_RDY", 32'(mem_RDY), 32'(a_cpu || a_dma));
        check("dbg_state", 32'(dbg_state_o), 32'(m_turn));
        check("burst_cap", 32'(dbg_burst_cnt_o <= 8'(MAX_BURST - 1)), 32'd1);
        if (m_turn) check("burst_cnt", 32'(dbg_burst_cnt_o), 32'(m_used));
        if (a_cpu) begin
            check("mem_AB_cpu", 32'(mem_AB), 32'(cpu_AB));
            check("mem_WE_cpu", 32'(mem_WE), 32'(cpu_WE));
            if (cpu_WE) check("mem_DO_cpu", 32'(mem_DO), 32'(cpu_DO));
        end
        if (ext_rdy && m_turn)
            check("mem_WE_dma", 32'(mem_WE), 32'(dma_req && dma_we && dma_addr < VEC_BASE));
        if (a_dma) begin
            check("mem_AB_dma", 32'(mem_AB), 32'(dma_addr));
            if (dma_we) check("mem_DO_dma", 32'(mem_DO), 32'(dma_wdata));
        end

        m_err = a_dma && dma_we && (dma_addr >= VEC_BASE);
        if (a_dma && !dma_we) exp_q.push_back(ref_rd(dma_addr));
        if (a_dma && dma_we && dma_addr < VEC_BASE) ref_mem[dma_addr] = dma_wdata;
        if (a_cpu) begin
            m_cpu_di    = ref_rd(cpu_AB);
            m_cpu_valid = 1'b1;
            if (cpu_WE && cpu_AB < VEC_BASE) ref_mem[cpu_AB] = cpu_DO;
        end
        // DMA keeps the port until the requester lets go or has used MAX_BURST grants.
        if (ext_rdy && !reset) begin
            if (!m_turn) begin
                if (dma_req) begin
                    m_turn = 1'b1;
                    m_used = 0;
                end
            end else if (!dma_req) begin
                m_turn = 1'b0;
            end else begin
                m_used++;
                if (m_used == MAX_BURST) m_turn = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] exp_rd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    function automatic logic [23:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return VEC_BASE + 24'($urandom_range(0, 15));
        return 24'($urandom_range(0, 63));
    endfunction

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ext_rdy = 1'b1;
        cpu_AB = '0; cpu_DO = '0; cpu_WE = 1'b0;
        dma_req = 1'b0; dma_addr = '0; dma_wdata = '0; dma_we = 1'b0;
        repeat (3) tick();
        at_neg();
        check("lit_rst_cpu_rdy", 32'(cpu_RDY), 32'd1);
        check("lit_rst_gnt", 32'(dma_gnt), 32'd0);
        check("lit_rst_rvalid", 32'(dma_rvalid), 32'd0);
        tick();

        // CPU read of 0x10, then a four-read DMA burst with the CPU data held.
        reset = 1'b0; cpu_AB = 24'h000010;
        at_neg(); tick();
        dma_req = 1'b1; dma_addr = 24'h001000;
        at_neg();
        check("lit_cpu_di_5a", 32'(cpu_DI), 32'h5A);
        check("lit_cpu_rdy_c1", 32'(cpu_RDY), 32'd1);
        tick();
        for (int k = 0; k < 5; k++) begin
            dma_req  = (k < 4);
            dma_addr = 24'h001000 + 24'(k);
            at_neg();
            check("lit_burst_gnt", 32'(dma_gnt), 32'(k < 4));
            check("lit_burst_rvalid", 32'(dma_rvalid), 32'(k > 0));
            if (k > 0) check("lit_burst_rdata", 32'(dma_rdata), 32'(exp_rd[k-1]));
            check("lit_cpu_di_hold", 32'(cpu_DI), 32'h5A);
            check("lit_cpu_stall", 32'(cpu_RDY), 32'd0);
            tick();
        end
        at_neg();
        check("lit_back_to_cpu", 32'(cpu_RDY), 32'd1);
        check("lit_rvalid_done", 32'(dma_rvalid), 32'd0);
        tick();

        // Continuous request: 16 grants, one CPU cycle, repeating.
        dma_req = 1'b1;
        for (int i = 0; i < 36; i++) begin
            dma_addr = 24'($urandom_range(0, 255));
            at_neg();
            check("lit_fair_gnt", 32'(dma_gnt), 32'(i % 17 != 0));
            check("lit_fair_cpu", 32'(cpu_RDY), 32'(i % 17 == 0));
            tick();
        end
        dma_req = 1'b0;
        at_neg(); tick();

        // ext_rdy low for 3 cycles after five grants; burst resumes at count 5.
        dma_req = 1'b1;
        repeat (6) begin
            dma_addr = 24'($urandom_range(0, 255));
            tick();
        end
        ext_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("lit_frz_mem_rdy", 32'(mem_RDY), 32'd0);
            check("lit_frz_gnt", 32'(dma_gnt), 32'd0);
            check("lit_frz_cpu_rdy", 32'(cpu_RDY), 32'd0);
            check("lit_frz_cnt", 32'(dbg_burst_cnt_o), 32'd5);
            tick();
        end
        ext_rdy = 1'b1;
        at_neg();
        check("lit_resume_gnt", 32'(dma_gnt), 32'd1);
        check("lit_resume_cnt", 32'(dbg_burst_cnt_o), 32'd5);
        tick();
        for (int i = 0; i < 11; i++) begin
            at_neg();
            check("lit_tail_gnt", 32'(dma_gnt), 32'(i < 10));
            check("lit_tail_cpu", 32'(cpu_RDY), 32'(i == 10));
            tick();
        end
        dma_req = 1'b0;
        at_neg(); tick();

        // DMA write into the vector region is dropped and flagged; a normal write lands.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 24'hFFFFF4; dma_wdata = 8'hA5;
        tick();
        at_neg();
        check("lit_vec_gnt", 32'(dma_gnt), 32'd1);
        check("lit_vec_we", 32'(mem_WE), 32'd0);
        tick();
        dma_addr = 24'h000300; dma_wdata = 8'h33;
        at_neg();
        check("lit_wr_gnt", 32'(dma_gnt), 32'd1);
        check("lit_wr_we", 32'(mem_WE), 32'd1);
        check("lit_err_pulse", 32'(dma_err), 32'd1);
        tick();
        dma_req = 1'b0; dma_we = 1'b0;
        at_neg();
        check("lit_err_clear", 32'(dma_err), 32'd0);
        tick();
        cpu_AB = 24'h000300;
        at_neg(); tick();
        at_neg();
        check("lit_cpu_rd_300", 32'(cpu_DI), 32'h33);
        tick();

        // Reset in the middle of a read burst.
        dma_req = 1'b1; dma_addr = 24'h000040;
        repeat (4) tick();
        reset = 1'b1;
        at_neg();
        check("lit_mid_rst_cpu_rdy", 32'(cpu_RDY), 32'd1);
        check("lit_mid_rst_gnt", 32'(dma_gnt), 32'd0);
        check("lit_mid_rst_rvalid", 32'(dma_rvalid), 32'd0);
        tick();
        reset = 1'b0; dma_req = 1'b0; cpu_AB = 24'h000200;
        at_neg(); tick();
        at_neg();
        check("lit_cpu_rd_200", 32'(cpu_DI), 32'h77);
        tick();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            ext_rdy   = ($urandom_range(0, 9) != 0);
            dma_req   = ($urandom_range(0, 99) < (((n / 500) % 2) != 0 ? 95 : 60));
            dma_we    = ($urandom_range(0, 2) == 0);
            dma_addr  = pick_addr();
            dma_wdata = 8'($urandom);
            cpu_AB    = pick_addr();
            cpu_WE    = ($urandom_range(0, 3) == 0);
            cpu_DO    = 8'($urandom);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; ext_rdy = 1'b1; dma_req = 1'b0; cpu_WE = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
